// File: rtl/gpr_file_pkg.sv
// Shared types and constants for the general-purpose register file.
// Provides the clear-engine state encoding and the hardwired-zero register address.
// No ports; imported by gpr_clear_fsm and gpr_file.
`include "defines.svh"

package gpr_file_pkg;

    localparam int GPR_DW  = `N_REG;
    localparam int GPR_AW  = `N_REG_ADDR;
    localparam int GPR_NUM = 1 << GPR_AW;

    typedef enum logic {
        GPR_CLEAR = 1'b0,
        GPR_READY = 1'b1
    } gpr_state_t;

    // r0 reads as zero and never accepts a write
    localparam logic [GPR_AW-1:0] GPR_ZERO_ADDR = '0;

endpackage

// File: rtl/defines.svh
`ifndef GPR_DEFINES_SVH
`define GPR_DEFINES_SVH

// Register file geometry
`define N_REG        32
`define N_REG_ADDR   5

// Active levels of the pipeline control strobes
`define READ_ENABLE  1'b1
`define WRITE_ENABLE 1'b1
`define RST_ENABLE   1'b0

`endif

// File: rtl/gpr_clear_fsm.sv
// Post-reset clear engine: walks r1..r(NUM_REGS-1) writing zero, one per cycle, then idles.
// Ports: i_clk/i_rst_n (sync, active-low); o_busy (registered stall request);
//        o_ready (array usable); o_clr_wen/o_clr_addr (zeroing write strobe and target).
`include "defines.svh"

module gpr_clear_fsm
    import gpr_file_pkg::*;
#(
    parameter int N_REG_ADDR = `N_REG_ADDR,
    parameter int NUM_REGS   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_busy,
    output logic                  o_ready,
    output logic                  o_clr_wen,
    output logic [N_REG_ADDR-1:0] o_clr_addr
);

    localparam logic [N_REG_ADDR-1:0] ONE_IDX  = N_REG_ADDR'(1);
    localparam logic [N_REG_ADDR-1:0] LAST_IDX = N_REG_ADDR'(NUM_REGS - 1);

    gpr_state_t            r_state;
    gpr_state_t            w_state_nxt;
    logic [N_REG_ADDR-1:0] r_cnt;
    logic [N_REG_ADDR-1:0] w_cnt_nxt;
    logic                  r_busy;
    logic                  w_clr_active;

    // Reset always restarts the sweep at r1; r0 is never stored.
    always_ff @(posedge i_clk) begin
        if (i_rst_n == `RST_ENABLE) begin
            r_state <= GPR_CLEAR;
            r_cnt   <= ONE_IDX;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Registered from the next state so busy drops on the same edge
            // that writes the last register.
            r_busy  <= (w_state_nxt == GPR_CLEAR);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_clr_active = 1'b0;
        case (r_state)
            GPR_CLEAR: begin
                w_clr_active = 1'b1;
                w_cnt_nxt    = r_cnt + ONE_IDX;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = GPR_READY;
                end
            end
            GPR_READY: begin
                w_state_nxt = GPR_READY;
            end
            default: begin
                w_state_nxt = GPR_CLEAR;
            end
        endcase
    end

    assign o_busy     = r_busy;
    assign o_ready    = (r_state == GPR_READY);
    assign o_clr_wen  = w_clr_active && (i_rst_n != `RST_ENABLE);
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/gpr_file.sv
// 32-entry GPR file: two combinational read ports with same-cycle WB bypass, one write port, r0 = 0.
// Ports: i_clk/i_rst_n (sync, active-low); i_wen/i_waddr/i_wdata (WB write);
//        i_reg_k_ren/i_reg_k_addr -> o_reg_k_data (k=0,1, 0-cycle); o_busy (stall while clearing).
`include "defines.svh"

module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int N_REG      = `N_REG,
    parameter int N_REG_ADDR = `N_REG_ADDR,
    parameter int NUM_REGS   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wen,
    input  logic [N_REG_ADDR-1:0] i_waddr,
    input  logic [N_REG-1:0]      i_wdata,
    input  logic                  i_reg_0_ren,
    input  logic [N_REG_ADDR-1:0] i_reg_0_addr,
    output logic [N_REG-1:0]      o_reg_0_data,
    input  logic                  i_reg_1_ren,
    input  logic [N_REG_ADDR-1:0] i_reg_1_addr,
    output logic [N_REG-1:0]      o_reg_1_data,
    output logic                  o_busy
);

    localparam logic [N_REG_ADDR-1:0] ZERO_ADDR = N_REG_ADDR'(GPR_ZERO_ADDR);

    // Storage has no reset; the clear engine initialises it after every reset.
    logic [N_REG-1:0]      r_mem [NUM_REGS];

    logic                  w_ready;
    logic                  w_clr_wen;
    logic [N_REG_ADDR-1:0] w_clr_addr;
    logic                  w_wb_wen;
    logic                  w_mem_wen;
    logic [N_REG_ADDR-1:0] w_mem_waddr;
    logic [N_REG-1:0]      w_mem_wdata;
    logic                  w_rd_open;
    logic                  w_bypass_hit;

    gpr_clear_fsm #(
        .N_REG_ADDR (N_REG_ADDR),
        .NUM_REGS   (NUM_REGS)
    ) u_clear_fsm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .o_busy     (o_busy),
        .o_ready    (w_ready),
        .o_clr_wen  (w_clr_wen),
        .o_clr_addr (w_clr_addr)
    );

    // WB writes only land once the clear has finished, and never into r0.
    assign w_wb_wen    = (i_rst_n != `RST_ENABLE) && w_ready &&
                         (i_wen == `WRITE_ENABLE) && (i_waddr != ZERO_ADDR);
    assign w_mem_wen   = w_clr_wen || w_wb_wen;
    assign w_mem_waddr = w_clr_wen ? w_clr_addr : i_waddr;
    assign w_mem_wdata = w_clr_wen ? '0 : i_wdata;

    always_ff @(posedge i_clk) begin
        if (w_mem_wen) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Reads are forced to zero during reset and clear so uninitialised
    // storage never reaches ID.
    assign w_rd_open    = (i_rst_n != `RST_ENABLE) && w_ready;
    assign w_bypass_hit = (i_wen == `WRITE_ENABLE);

    always_comb begin
        o_reg_0_data = '0;
        if (w_rd_open && (i_reg_0_ren == `READ_ENABLE) && (i_reg_0_addr != ZERO_ADDR)) begin
            if (w_bypass_hit && (i_waddr == i_reg_0_addr)) begin
                o_reg_0_data = i_wdata;
            end else begin
                o_reg_0_data = r_mem[i_reg_0_addr];
            end
        end
    end

    always_comb begin
        o_reg_1_data = '0;
        if (w_rd_open && (i_reg_1_ren == `READ_ENABLE) && (i_reg_1_addr != ZERO_ADDR)) begin
            if (w_bypass_hit && (i_waddr == i_reg_1_addr)) begin
                o_reg_1_data = i_wdata;
            end else begin
                o_reg_1_data = r_mem[i_reg_1_addr];
            end
        end
    end

endmodule

// File: tb/tb_gpr_file.sv
// Randomised and directed bench for gpr_file against an array-based reference model.
// Inputs change on the falling edge; outputs are sampled shortly after, before the rising edge.
// Bounded waits only; every comparison goes through chk().
module tb_gpr_file;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_wen;
    logic [4:0]  i_waddr;
    logic [31:0] i_wdata;
    logic        i_reg_0_ren;
    logic [4:0]  i_reg_0_addr;
    logic [31:0] o_reg_0_data;
    logic        i_reg_1_ren;
    logic [4:0]  i_reg_1_addr;
    logic [31:0] o_reg_1_data;
    logic        o_busy;

    int n_checks;
    int n_errors;

    // Reference model: architectural register contents plus clear progress.
    logic [31:0] m_mem [32];
    bit          m_known;
    bit          m_ready;
    int          m_left;
    logic        obs_busy;

    gpr_file dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_wen        (i_wen),
        .i_waddr      (i_waddr),
        .i_wdata      (i_wdata),
        .i_reg_0_ren  (i_reg_0_ren),
        .i_reg_0_addr (i_reg_0_addr),
        .o_reg_0_data (o_reg_0_data),
        .i_reg_1_ren  (i_reg_1_ren),
        .i_reg_1_addr (i_reg_1_addr),
        .o_reg_1_data (o_reg_1_data),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic ren, input logic [4:0] addr);
        if (!i_rst_n || !m_ready || !ren || addr == 5'd0) return 32'h0;
        if (i_wen && i_waddr == addr) return i_wdata;
        return m_mem[addr];
    endfunction

    task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r0en, input logic [4:0] a0,
                         input logic r1en, input logic [4:0] a1);
        i_wen        = wen;
        i_waddr      = wa;
        i_wdata      = wd;
        i_reg_0_ren  = r0en;
        i_reg_0_addr = a0;
        i_reg_1_ren  = r1en;
        i_reg_1_addr = a1;
    endtask

    // One clock: check outputs against the model, take the edge, update the model.
    task automatic step();
        #1;
        obs_busy = o_busy;
        if (m_known) begin
            chk("busy", {31'd0, o_busy}, {31'd0, !m_ready});
            chk("rd0", o_reg_0_data, exp_read(i_reg_0_ren, i_reg_0_addr));
            chk("rd1", o_reg_1_data, exp_read(i_reg_1_ren, i_reg_1_addr));
        end
        @(posedge i_clk);
        if (!i_rst_n) begin
            m_known = 1'b1;
            m_ready = 1'b0;
            m_left  = 31;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            end
        end else if (i_wen && i_waddr != 5'd0) begin
            m_mem[i_waddr] = i_wdata;
        end
        @(negedge i_clk);
    endtask

    // Runs from reset release until busy drops; pulses a write to r3 mid-clear.
    task automatic wait_ready();
        int n;
        int k;
        n = 0;
        k = 0;
        do begin
            drive(k == 5, 5'd3, 32'h1, 1'b1, 5'($urandom_range(0, 31)), 1'b1, 5'd3);
            step();
            if (obs_busy) n++;
            k++;
        end while (obs_busy && k < 100);
        chk("busy_len", n, 31);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_known  = 1'b0;
        m_ready  = 1'b0;
        m_left   = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        i_rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);
        @(negedge i_clk);

        // Reset held for three cycles, then the initial clear.
        repeat (3) step();
        chk("busy_in_reset", {31'd0, o_busy}, 32'd1);
        i_rst_n = 1'b1;
        wait_ready();

        for (int a = 1; a < 32; a++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(32 - a));
            #1;
            chk("init_zero", o_reg_0_data, 32'h0);
            step();
        end

        // Write then read r5, with and without read enable.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5);
        #1;
        chk("r5_read", o_reg_0_data, 32'hDEADBEEF);
        chk("r5_ren0", o_reg_1_data, 32'h0);
        step();

        // Same-cycle bypass hides the previous content of r7.
        drive(1'b1, 5'd7, 32'hAAAA0000, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7);
        #1;
        chk("byp_p0", o_reg_0_data, 32'h12345678);
        chk("byp_p1", o_reg_1_data, 32'h12345678);
        step();

        // r0 stays zero whether or not it is read while being written.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        chk("r0_same", o_reg_0_data, 32'h0);
        step();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        chk("r0_after", o_reg_1_data, 32'h0);
        step();

        // Back-to-back writes r1=1, r2=2, r1=3 with both ports watching.
        begin
            logic [4:0]  wa [3];
            logic [31:0] wd [3];
            logic [31:0] e0 [3];
            logic [31:0] e1 [3];
            wa = '{5'd1, 5'd2, 5'd1};
            wd = '{32'd1, 32'd2, 32'd3};
            e0 = '{32'd1, 32'd1, 32'd3};
            e1 = '{32'd0, 32'd2, 32'd2};
            for (int i = 0; i < 3; i++) begin
                drive(1'b1, wa[i], wd[i], 1'b1, 5'd1, 1'b1, 5'd2);
                #1;
                chk("b2b_p0", o_reg_0_data, e0[i]);
                chk("b2b_p1", o_reg_1_data, e1[i]);
                step();
            end
        end

        // Random traffic; read addresses often alias the write address.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 1) == 1, wa, $urandom,
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
            step();
        end

        // Reset mid-clear restarts the sweep and wipes earlier writes.
        drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
        #1;
        chk("r9_set", o_reg_0_data, 32'h55);
        i_rst_n = 1'b0;
        repeat (2) step();
        i_rst_n = 1'b1;
        repeat (10) step();
        chk("busy_midclr", {31'd0, o_busy}, 32'd1);
        i_rst_n = 1'b0;
        repeat (2) step();
        i_rst_n = 1'b1;
        wait_ready();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd3);
        #1;
        chk("r9_cleared", o_reg_0_data, 32'h0);
        chk("r3_ignored", o_reg_1_data, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
